// File: rtl/llander_input_pkg.sv
// Shared types and default constants for the Lunar Lander input conditioner.
package llander_input_pkg;

  typedef logic [7:0] thrust_t;

  localparam int LL_THRUST_MAX = 254;
  localparam int LL_TURN_ON    = 64;
  localparam int LL_TURN_OFF   = 48;
  localparam int LL_TICK_DIV   = 98425;
  localparam int LL_SLEW_STEP  = 4;

endpackage

// File: rtl/llander_thrust_ctrl_turn_hysteresis.sv
// Set/clear comparator flag on a signed 9-bit stick axis; BELOW selects the
// negative side (set when x < SET_TH, clear when x > CLR_TH).
module turn_hysteresis
  #(parameter int SET_TH = 64,
    parameter int CLR_TH = 48,
    parameter bit BELOW  = 1'b0)
  (input  logic              clk_sys,
   input  logic              reset,
   input  logic signed [8:0] x,
   output logic              flag_nxt);

  localparam logic signed [8:0] SET_S = 9'(SET_TH);
  localparam logic signed [8:0] CLR_S = 9'(CLR_TH);

  logic flag;
  logic set_hit;
  logic clr_hit;

  always_comb begin
    set_hit  = BELOW ? (x < SET_S) : (x > SET_S);
    clr_hit  = BELOW ? (x > CLR_S) : (x < CLR_S);
    flag_nxt = flag;
    if (set_hit)
      flag_nxt = 1'b1;
    else if (clr_hit)
      flag_nxt = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset)
      flag <= 1'b0;
    else
      flag <= flag_nxt;
  end

endmodule

// File: rtl/llander_thrust_ctrl.sv
// Joystick/d-pad conditioner feeding the Lunar Lander THRUST lever and rotate inputs.
// Optional macro THRUST_SLEW_EN: analog thrust slews toward target on prescaler ticks.
module llander_thrust_ctrl
  import llander_input_pkg::*;
  #(parameter int TICK_DIV   = LL_TICK_DIV,
    parameter int THRUST_MAX = LL_THRUST_MAX,
    parameter int TURN_ON    = LL_TURN_ON,
`ifdef THRUST_SLEW_EN
    parameter int TURN_OFF   = LL_TURN_OFF,
    parameter int SLEW_STEP  = LL_SLEW_STEP
`else
    parameter int TURN_OFF   = LL_TURN_OFF
`endif
  )
  (input  logic       clk_sys,
   input  logic       reset,
   input  logic       mode_dpad,
   input  logic       joy_up,
   input  logic       joy_down,
   input  logic       joy_left,
   input  logic       joy_right,
   input  logic [7:0] analog_x,
   input  logic [7:0] analog_y,
   output logic [7:0] thrust,
   output logic       rot_left_l,
   output logic       rot_right_l);

  localparam int      CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam thrust_t TMAX  = thrust_t'(THRUST_MAX);

  function automatic thrust_t sat_target(input logic signed [8:0] t);
    if (t < 9'sd0)
      return '0;
    else if (t > $signed({1'b0, TMAX}))
      return TMAX;
    else
      return t[7:0];
  endfunction

`ifdef THRUST_SLEW_EN
  localparam thrust_t STEP = thrust_t'(SLEW_STEP);

  // Final step lands exactly on target, so thrust never overshoots.
  function automatic thrust_t slew_toward(input thrust_t cur, input thrust_t tgt);
    thrust_t diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (diff > STEP) ? cur + STEP : tgt;
    end else begin
      diff = cur - tgt;
      return (diff > STEP) ? cur - STEP : tgt;
    end
  endfunction
`endif

  logic [CNT_W-1:0]  presc_cnt;
  logic              tick;
  logic signed [8:0] y_s;
  logic signed [8:0] x_s;
  logic signed [8:0] target_s;
  thrust_t           target;
  logic              mode_p1;
  logic              dpad_rise;
  thrust_t           acc;
  thrust_t           acc_nxt;
  thrust_t           analog_nxt;
  thrust_t           thrust_nxt;
  logic              left_nxt;
  logic              right_nxt;

  assign tick = (presc_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset || tick)
      presc_cnt <= '0;
    else
      presc_cnt <= presc_cnt + 1'b1;
  end

  // Stage 0: combinational targets from the raw stick and d-pad state
  assign y_s       = {analog_y[7], analog_y};
  assign x_s       = {analog_x[7], analog_x};
  assign target_s  = 9'sd127 - y_s;
  assign target    = sat_target(target_s);
  assign dpad_rise = mode_dpad & ~mode_p1;

  // Accumulator picks up the live thrust on entry so the lever does not jump.
  always_comb begin
    acc_nxt = acc;
    if (dpad_rise)
      acc_nxt = thrust;
    else if (mode_dpad && tick) begin
      if (joy_up && !joy_down && (acc < TMAX))
        acc_nxt = acc + 8'd1;
      else if (joy_down && !joy_up && (acc != '0))
        acc_nxt = acc - 8'd1;
    end
  end

  always_comb begin
`ifdef THRUST_SLEW_EN
    analog_nxt = tick ? slew_toward(thrust, target) : thrust;
`else
    analog_nxt = target;
`endif
    thrust_nxt = mode_dpad ? acc_nxt : analog_nxt;
  end

  turn_hysteresis #(.SET_TH(-TURN_ON), .CLR_TH(-TURN_OFF), .BELOW(1'b1)) u_left (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .x        (x_s),
    .flag_nxt (left_nxt)
  );

  turn_hysteresis #(.SET_TH(TURN_ON), .CLR_TH(TURN_OFF), .BELOW(1'b0)) u_right (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .x        (x_s),
    .flag_nxt (right_nxt)
  );

  // Stage 1: registered outputs to the core
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mode_p1     <= 1'b0;
      acc         <= '0;
      thrust      <= '0;
      rot_left_l  <= 1'b1;
      rot_right_l <= 1'b1;
    end else begin
      mode_p1     <= mode_dpad;
      acc         <= acc_nxt;
      thrust      <= thrust_nxt;
      rot_left_l  <= ~(joy_left | left_nxt);
      rot_right_l <= ~(joy_right | right_nxt);
    end
  end

endmodule
